lsu_rmw: RTL and testbench

Load/store unit sitting directly upstream of the data memory, between the execute stage and `dmem`. The data memory only accepts full 32-bit word writes, so this block implements byte and halfword stores as read-modify-write sequences. It also extracts and sign- or zero-extends byte/halfword loads and flags misaligned or illegal accesses. It runs one request at a time behind a valid/ready handshake; the pipeline stalls while `o_ready` is low.

---
 rtl/lsu_rmw_if.sv | 27 ++
 rtl/lsu_rmw.sv | 150 +++++++++++++++
 tb/tb_lsu_rmw.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_rmw_if.sv
// Request/response and data-memory bus between the execute stage, lsu_rmw and dmem.
// The slave modport is the load/store unit; the master modport is its environment.
interface lsu_rmw_if;
  logic        i_valid;
  logic        i_wren;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_ready;
  logic        o_done;
  logic        o_err;
  logic [31:0] o_rdata;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        o_mem_wren;
  logic [31:0] i_mem_rdata;

  modport slave (
    input  i_valid, i_wren, i_funct3, i_addr, i_wdata, i_mem_rdata,
    output o_ready, o_done, o_err, o_rdata, o_mem_addr, o_mem_wdata, o_mem_wren
  );

  modport master (
    output i_valid, i_wren, i_funct3, i_addr, i_wdata, i_mem_rdata,
    input  o_ready, o_done, o_err, o_rdata, o_mem_addr, o_mem_wdata, o_mem_wren
  );
endinterface

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-only dmem: byte/halfword stores become
// read-modify-write sequences, sub-word loads are lane-selected and extended.
module lsu_rmw (
  input  logic       i_clk,
  input  logic       i_reset,
  lsu_rmw_if.slave   bus
);

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, READ, CAPTURE, WRITE} state_t;

  state_t      state_q, state_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic        wren_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic        accept;
  logic        req_err;

  // Misaligned and illegal requests both end in the same error pulse.
  function automatic logic bad_request(input logic wren, input logic [2:0] f3,
                                       input logic [1:0] a);
    case (f3)
      F3_B:    bad_request = 1'b0;
      F3_H:    bad_request = a[0];
      F3_W:    bad_request = |a;
      F3_BU:   bad_request = wren;
      F3_HU:   bad_request = wren | a[0];
      default: bad_request = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0] f3,
                                               input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (f3)
      F3_B:    load_extract = {{24{b[7]}}, b};
      F3_BU:   load_extract = {24'd0, b};
      F3_H:    load_extract = {{16{h[15]}}, h};
      F3_HU:   load_extract = {16'd0, h};
      default: load_extract = word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [2:0] f3,
                                              input logic [1:0] lane,
                                              input logic [15:0] data);
    store_merge = word;
    if (f3 == F3_H) store_merge[{lane[1], 4'b0000} +: 16] = data;
    else            store_merge[{lane, 3'b000} +: 8]      = data[7:0];
  endfunction

  assign accept  = bus.i_valid && (state_q == IDLE);
  assign req_err = bad_request(bus.i_wren, bus.i_funct3, bus.i_addr[1:0]);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (bus.i_wren && bus.i_funct3 == F3_W) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ:    state_d = CAPTURE;
      CAPTURE: begin
        state_d = wren_q ? WRITE : IDLE;
        done_d  = !wren_q;
      end
      WRITE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the request latch is pure datapath, consumed only in states that
  // follow an accept, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      wren_q   <= bus.i_wren;
      funct3_q <= bus.i_funct3;
      lane_q   <= bus.i_addr[1:0];
      wdata_q  <= bus.i_wdata[15:0];
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (accept && !req_err) begin
        mem_addr_q <= {bus.i_addr[31:2], 2'b00};
        if (bus.i_wren && bus.i_funct3 == F3_W) mem_wdata_q <= bus.i_wdata;
      end
      // dmem read data for the READ address arrives during CAPTURE.
      if (state_q == CAPTURE) begin
        if (wren_q) mem_wdata_q <= store_merge(bus.i_mem_rdata, funct3_q, lane_q, wdata_q);
        else        rdata_q     <= load_extract(bus.i_mem_rdata, funct3_q, lane_q);
      end
    end
  end

  assign bus.o_ready     = (state_q == IDLE);
  assign bus.o_done      = done_q;
  assign bus.o_err       = err_q;
  assign bus.o_rdata     = rdata_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_mem_wren  = (state_q == WRITE);

endmodule

// File: tb/tb_lsu_rmw.sv
// Bench for lsu_rmw: a registered-read dmem model, a reference memory and a
// scoreboard of expected completions and dmem writes checked at the negedge.
module tb_lsu_rmw;

  typedef struct {
    logic        err;
    logic        is_load;
    logic [31:0] rdata;
    int          done_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wexp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_rmw_if bus ();
  lsu_rmw dut (.i_clk(clk), .i_reset(rst_n), .bus(bus));

  // dmem model: one-cycle registered read, word write, side preload port.
  logic [31:0] dmem [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;
  always @(posedge clk) begin
    if (pl_en)                dmem[pl_idx] <= pl_data;
    else if (bus.o_mem_wren)  dmem[bus.o_mem_addr[7:2]] <= bus.o_mem_wdata;
    bus.i_mem_rdata <= dmem[bus.o_mem_addr[7:2]];
  end

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] ref_mem [0:63];
  logic [31:0] model_rdata = 32'd0;
  exp_t        sb[$];
  wexp_t       wq[$];
  int          busy_from = -10;
  int          busy_until = -10;
  int          addr_cyc = -10;
  logic [31:0] addr_exp = 32'd0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] a);
    logic [31:0] s;
    s = w >> (8 * a);
    case (f3)
      3'd0:    ld_model = {{24{s[7]}}, s[7:0]};
      3'd4:    ld_model = {24'd0, s[7:0]};
      3'd1:    ld_model = {{16{s[15]}}, s[15:0]};
      3'd5:    ld_model = {16'd0, s[15:0]};
      default: ld_model = w;
    endcase
  endfunction

  function automatic logic [31:0] st_model(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] a, input logic [31:0] d);
    logic [31:0] m;
    if (f3 == 3'd2) return d;
    m = (f3 == 3'd1 ? 32'h0000_FFFF : 32'h0000_00FF) << (8 * a);
    return (w & ~m) | ((d << (8 * a)) & m);
  endfunction

  // Monitor: ready/busy, read address, dmem writes and completions.
  always @(negedge clk) begin
    if (mon_en) begin
      if (cyc >= busy_from && cyc <= busy_until) check("ready_busy", 32'(bus.o_ready), 32'd0);
      else                                       check("ready_idle", 32'(bus.o_ready), 32'd1);
      if (cyc == addr_cyc) check("mem_addr_c1", bus.o_mem_addr, addr_exp);
      if (bus.o_mem_wren) begin
        if (wq.size() == 0) check("spurious_write", 32'(bus.o_mem_wren), 32'd0);
        else begin
          wexp_t w;
          w = wq.pop_front();
          check("wr_cycle", 32'(cyc), 32'(w.cyc));
          check("wr_addr", bus.o_mem_addr, w.addr);
          check("wr_data", bus.o_mem_wdata, w.data);
        end
      end
      if (bus.o_done) begin
        if (sb.size() == 0) check("spurious_done", 32'(bus.o_done), 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.done_cyc));
          check("err", 32'(bus.o_err), 32'(e.err));
          if (e.is_load && !e.err) model_rdata = e.rdata;
          check("rdata", bus.o_rdata, model_rdata);
        end
      end
    end
  end

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    pl_en = 1'b1; pl_idx = addr[7:2]; pl_data = data;
    ref_mem[addr[7:2]] = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Drives a request and holds it until accepted; returns 1 time unit into cycle 1.
  task automatic issue(input logic wren, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit track);
    int          n;
    int          acc;
    int          lat;
    logic        err;
    logic [31:0] w;
    exp_t        e;
    bus.i_valid = 1'b1; bus.i_wren = wren; bus.i_funct3 = f3;
    bus.i_addr = addr; bus.i_wdata = wdata;
    n = 0;
    @(negedge clk);
    while (!bus.o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_ready) check("accept_timeout", 32'(bus.o_ready), 32'd1);
    else if (track) begin
      acc = cyc + 1;
      err = (f3 == 3'd3 || f3 > 3'd5) || (wren && f3 >= 3'd4) ||
            ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) || (f3 == 3'd2 && addr[1:0] != 2'd0);
      lat = err ? 1 : (!wren ? 3 : (f3 == 3'd2 ? 2 : 4));
      w = ref_mem[addr[7:2]];
      e.err = err; e.is_load = !wren; e.rdata = ld_model(w, f3, addr[1:0]);
      e.done_cyc = acc + lat - 1;
      sb.push_back(e);
      busy_from = acc; busy_until = acc + lat - 2;
      if (!err) begin
        addr_cyc = acc; addr_exp = {addr[31:2], 2'b00};
        if (wren) begin
          w = st_model(w, f3, addr[1:0], wdata);
          wq.push_back('{addr: {addr[31:2], 2'b00}, data: w, cyc: acc + lat - 2});
          ref_mem[addr[7:2]] = w;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    bus.i_valid = 1'b0;
    n = 0;
    while ((sb.size() != 0 || wq.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0 || wq.size() != 0)
      check("drain_timeout", 32'(sb.size() + wq.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values();
    check("rst_ready", 32'(bus.o_ready), 32'd1);
    check("rst_done", 32'(bus.o_done), 32'd0);
    check("rst_err", 32'(bus.o_err), 32'd0);
    check("rst_rdata", bus.o_rdata, 32'd0);
    check("rst_mem_addr", bus.o_mem_addr, 32'd0);
    check("rst_mem_wdata", bus.o_mem_wdata, 32'd0);
    check("rst_mem_wren", 32'(bus.o_mem_wren), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; pl_en = 1'b0; pl_idx = 6'd0; pl_data = 32'd0;
    bus.i_valid = 1'b0; bus.i_wren = 1'b0; bus.i_funct3 = 3'd0;
    bus.i_addr = 32'd0; bus.i_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Word store.
    issue(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b1);
    drain();

    // Byte and halfword read-modify-write.
    preload(32'h10, 32'h1122_3344);
    issue(1'b1, 3'd0, 32'h12, 32'h0000_00AB, 1'b1);
    drain();
    preload(32'h10, 32'h1122_3344);
    issue(1'b1, 3'd1, 32'h12, 32'h0000_BEEF, 1'b1);
    drain();

    // Loads with sign and zero extension.
    preload(32'h10, 32'h8001_F0FF);
    issue(1'b0, 3'd2, 32'h10, 32'd0, 1'b1); drain();
    issue(1'b0, 3'd0, 32'h10, 32'd0, 1'b1); drain();
    issue(1'b0, 3'd4, 32'h10, 32'd0, 1'b1); drain();
    issue(1'b0, 3'd1, 32'h12, 32'd0, 1'b1); drain();
    issue(1'b0, 3'd5, 32'h12, 32'd0, 1'b1); drain();
    issue(1'b0, 3'd0, 32'h11, 32'd0, 1'b1); drain();

    // Misaligned and illegal requests.
    issue(1'b0, 3'd2, 32'h11, 32'd0, 1'b1);
    issue(1'b1, 3'd1, 32'h13, 32'h1234, 1'b1);
    issue(1'b1, 3'd2, 32'h12, 32'hCAFE_F00D, 1'b1);
    issue(1'b0, 3'd3, 32'h10, 32'd0, 1'b1);
    issue(1'b1, 3'd4, 32'h10, 32'h77, 1'b1);
    issue(1'b0, 3'd6, 32'h10, 32'd0, 1'b1);
    issue(1'b1, 3'd5, 32'h10, 32'h77, 1'b1);
    drain();

    // Back-to-back: SB then LW with valid held high.
    preload(32'h10, 32'h1122_3344);
    issue(1'b1, 3'd0, 32'h13, 32'h0000_0055, 1'b1);
    issue(1'b0, 3'd2, 32'h10, 32'd0, 1'b1);
    drain();

    // Reset during CAPTURE of a halfword store.
    mon_en = 1'b0;
    issue(1'b1, 3'd1, 32'h12, 32'h0000_1234, 1'b0);
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_unchanged", dmem[4], ref_mem[4]);
    rst_n = 1'b1;
    model_rdata = 32'd0;
    busy_from = -10; busy_until = -10;
    mon_en = 1'b1;
    issue(1'b0, 3'd2, 32'h10, 32'd0, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
